dpram_copy_master: RTL and testbench

DPRAM_COPY_MASTER -- requirements
Module: dpram_copy_master

---
 rtl/dpram_copy_master_if.sv | 47 ++++
 rtl/dpram_copy_master.sv | 133 +++++++++++++
 tb/tb_dpram_copy_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_copy_master_if.sv
// rtl/dpram_copy_master_if.sv - Bundle of the copy master's command, RAM port A/B and status signals
// Ports: none (signal bundle only)
//   master modport : the copy engine (drives RAM requests and status, receives command and RAM responses)
//   slave modport  : the environment (issues commands, acts as the dual-port RAM)
interface dpram_copy_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    // Command
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   len;
    // RAM port A (read side)
    logic              valid_a;
    logic              ready_a;
    logic [ADDR_W-1:0] addr_a;
    logic              we_a;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] q_a;
    // RAM port B (write side)
    logic              valid_b;
    logic              ready_b;
    logic [ADDR_W-1:0] addr_b;
    logic              we_b;
    logic [DATA_W-1:0] data_b;
    // Status
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   xfer_cnt;

    modport master (
        input  start, src_addr, dst_addr, len,
        input  ready_a, q_a, ready_b,
        output valid_a, addr_a, we_a, data_a,
        output valid_b, addr_b, we_b, data_b,
        output busy, done, xfer_cnt
    );

    modport slave (
        output start, src_addr, dst_addr, len,
        output ready_a, q_a, ready_b,
        input  valid_a, addr_a, we_a, data_a,
        input  valid_b, addr_b, we_b, data_b,
        input  busy, done, xfer_cnt
    );
endinterface

// File: rtl/dpram_copy_master.sv
// rtl/dpram_copy_master.sv - Word-by-word copy engine between two ports of a dual-port RAM
// Ports:
//   clk  : rising-edge clock for all state
//   rst  : asynchronous active-high reset
//   bus  : dpram_copy_master_if.master
//          start/src_addr/dst_addr/len  copy command (sampled in IDLE only)
//          valid_a/ready_a/addr_a/q_a   read requests on port A (we_a/data_a tied to 0)
//          valid_b/ready_b/addr_b/data_b/we_b  write requests on port B
//          busy/done/xfer_cnt           status
module dpram_copy_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dpram_copy_master_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   xfer_cnt;
    logic              valid_a;
    logic [ADDR_W-1:0] addr_a;
    logic              valid_b;
    logic [ADDR_W-1:0] addr_b;
    // Captured read word; it is presented directly as the write data.
    logic [DATA_W-1:0] buffer;
    logic              busy;
    logic              done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            xfer_cnt <= '0;
            valid_a  <= 1'b0;
            addr_a   <= '0;
            valid_b  <= 1'b0;
            addr_b   <= '0;
            buffer   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        src_q    <= bus.src_addr;
                        dst_q    <= bus.dst_addr;
                        len_q    <= bus.len;
                        xfer_cnt <= '0;
                        if (bus.len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RD;
                            busy    <= 1'b1;
                            valid_a <= 1'b1;
                            addr_a  <= bus.src_addr;
                        end
                    end
                end
                RD: begin
                    // valid_a and addr_a simply hold while ready_a is low.
                    if (bus.ready_a) begin
                        valid_a <= 1'b0;
                        state   <= CAP;
                    end
                end
                CAP: begin
                    // q_a belongs to the handshake accepted on the previous edge.
                    buffer  <= bus.q_a;
                    valid_b <= 1'b1;
                    addr_b  <= dst_q + xfer_cnt[ADDR_W-1:0];
                    state   <= WR;
                end
                WR: begin
                    if (bus.ready_b) begin
                        valid_b  <= 1'b0;
                        xfer_cnt <= xfer_cnt + CNT_ONE;
                        if ((xfer_cnt + CNT_ONE) == len_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= RD;
                            valid_a <= 1'b1;
                            // Low bits of the count wrap naturally modulo 2^ADDR_W.
                            addr_a  <= src_q + xfer_cnt[ADDR_W-1:0] + ADDR_ONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    valid_a <= 1'b0;
                    valid_b <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid_a  = valid_a;
    assign bus.addr_a   = addr_a;
    assign bus.we_a     = 1'b0;
    assign bus.data_a   = '0;
    assign bus.valid_b  = valid_b;
    assign bus.addr_b   = addr_b;
    assign bus.we_b     = valid_b;
    assign bus.data_b   = buffer;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.xfer_cnt = xfer_cnt;
endmodule

// File: tb/tb_dpram_copy_master.sv
// tb/tb_dpram_copy_master.sv - Randomized self-checking bench for dpram_copy_master
module tb_dpram_copy_master;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    dpram_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dpram_copy_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] exp_ram [DEPTH];
    int            rd_log[$];
    int            wr_addr_log[$];
    int            wr_data_log[$];

    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall first write 5 cycles
    int stall_left = 0;
    int stall_seen = 0;

    logic            pv_a, pv_b;
    logic [AW-1:0]   p_addr_a, p_addr_b;
    logic [DW-1:0]   p_data_b;
    logic [AW:0]     p_xfer;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Dual-port RAM: read data one cycle after the read handshake.
    always @(posedge clk) begin
        if (!rst && bus.valid_a && bus.ready_a) begin
            bus.q_a <= ram[bus.addr_a];
            rd_log.push_back(int'(bus.addr_a));
        end
        if (!rst && bus.valid_b && bus.ready_b) begin
            ram[bus.addr_b] <= bus.data_b;
            wr_addr_log.push_back(int'(bus.addr_b));
            wr_data_log.push_back(int'(bus.data_b));
        end
    end

    // Ready generation, changed shortly after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                1: begin
                    bus.ready_a = ($urandom_range(0, 3) != 0);
                    bus.ready_b = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    bus.ready_a = 1'b1;
                    if (bus.valid_b && stall_left > 0) begin
                        bus.ready_b = 1'b0;
                        stall_left--;
                    end else begin
                        bus.ready_b = 1'b1;
                    end
                end
                default: begin
                    bus.ready_a = 1'b1;
                    bus.ready_b = 1'b1;
                end
            endcase
        end
    end

    // Protocol monitor, sampled 1 time unit after each rising edge. The ready
    // visible at that point is the one the just-passed edge used.
    initial begin
        pv_a = 1'b0;
        pv_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                check("excl_ab", 32'(bus.valid_a & bus.valid_b), 0);
                check("we_b", 32'(bus.we_b), 32'(bus.valid_b));
                check("we_a", 32'(bus.we_a), 0);
                check("data_a", 32'(bus.data_a), 0);
                if (pv_b && !bus.ready_b) begin
                    stall_seen++;
                    check("stall_valid_b", 32'(bus.valid_b), 1);
                    check("stall_addr_b", 32'(bus.addr_b), 32'(p_addr_b));
                    check("stall_data_b", 32'(bus.data_b), 32'(p_data_b));
                    check("stall_xfer", 32'(bus.xfer_cnt), 32'(p_xfer));
                end
                if (pv_a && !bus.ready_a) begin
                    check("stall_valid_a", 32'(bus.valid_a), 1);
                    check("stall_addr_a", 32'(bus.addr_a), 32'(p_addr_a));
                end
            end
            pv_a     = rst ? 1'b0 : bus.valid_a;
            pv_b     = rst ? 1'b0 : bus.valid_b;
            p_addr_a = bus.addr_a;
            p_addr_b = bus.addr_b;
            p_data_b = bus.data_b;
            p_xfer   = bus.xfer_cnt;
        end
    end

    task automatic compare_ram(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, 32'(ram[i]), 32'(exp_ram[i]));
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    // One copy command; the reference is a plain sequential word loop.
    task automatic run_copy(input int src, input int dst, input int ln,
                            input int rmode, input bit chk_lat, input bit poke);
        int exp_ra[$];
        int exp_wa[$];
        int exp_wd[$];
        int n;
        int budget;
        for (int i = 0; i < ln; i++) begin
            int s = (src + i) % DEPTH;
            int d = (dst + i) % DEPTH;
            exp_ra.push_back(s);
            exp_wa.push_back(d);
            exp_wd.push_back(int'(exp_ram[s]));
            exp_ram[d] = exp_ram[s];
        end
        ready_mode = rmode;
        stall_left = 5;
        stall_seen = 0;
        clear_logs();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = AW'(src);
        bus.dst_addr = AW'(dst);
        bus.len      = (AW+1)'(ln);
        @(posedge clk);
        #1;
        n = 1;
        bus.start    = 1'b0;
        bus.src_addr = AW'($urandom);
        bus.dst_addr = AW'($urandom);
        bus.len      = (AW+1)'($urandom_range(1, DEPTH));
        check("busy_after_start", 32'(bus.busy), (ln != 0) ? 1 : 0);
        budget = 20 * ln + 20;
        while (!bus.done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 4) begin
                bus.start    = 1'b1;
                bus.src_addr = AW'($urandom);
                bus.dst_addr = AW'($urandom);
                bus.len      = (AW+1)'($urandom_range(1, DEPTH));
            end
            if (poke && n == 5) bus.start = 1'b0;
        end
        check("done_seen", 32'(bus.done), 1);
        if (chk_lat) check("done_latency", n, 3 * ln + 1);
        check("busy_at_done", 32'(bus.busy), 0);
        check("xfer_final", 32'(bus.xfer_cnt), ln);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 0);
        check("xfer_hold", 32'(bus.xfer_cnt), ln);
        if (rmode == 2 && ln > 0) check("stall_cycles", stall_seen, 5);
        check("n_reads", rd_log.size(), ln);
        check("n_writes", wr_addr_log.size(), ln);
        for (int i = 0; i < ln && i < rd_log.size(); i++) check("rd_addr", rd_log[i], exp_ra[i]);
        for (int i = 0; i < ln && i < wr_addr_log.size(); i++) begin
            check("wr_addr", wr_addr_log[i], exp_wa[i]);
            check("wr_data", wr_data_log[i], exp_wd[i]);
        end
        compare_ram("ram_after_copy");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid_a"}, 32'(bus.valid_a), 0);
        check({tag, "_valid_b"}, 32'(bus.valid_b), 0);
        check({tag, "_we_b"}, 32'(bus.we_b), 0);
        check({tag, "_addr_a"}, 32'(bus.addr_a), 0);
        check({tag, "_addr_b"}, 32'(bus.addr_b), 0);
        check({tag, "_data_b"}, 32'(bus.data_b), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_xfer"}, 32'(bus.xfer_cnt), 0);
    endtask

    // Reset during the second write of an 8-word copy: only word 0 lands.
    task automatic reset_mid_copy(input int src, input int dst);
        int n;
        ready_mode = 0;
        clear_logs();
        exp_ram[dst % DEPTH] = exp_ram[src % DEPTH];
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = AW'(src);
        bus.dst_addr = AW'(dst);
        bus.len      = (AW+1)'(8);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (!(bus.valid_b && bus.xfer_cnt == 1) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_reached_wr2", 32'(bus.valid_b && bus.xfer_cnt == 1), 1);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_abort");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        check("rst_n_writes", wr_addr_log.size(), 1);
        compare_ram("ram_after_abort");
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len      = '0;
        bus.ready_a  = 1'b1;
        bus.ready_b  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = DW'($urandom);
            exp_ram[i] = ram[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic copy with latency check
        ram[0] = 8'd11; ram[1] = 8'd22; ram[2] = 8'd33; ram[3] = 8'd44;
        for (int i = 0; i < 4; i++) exp_ram[i] = ram[i];
        run_copy(0, 10, 4, 0, 1, 0);

        // Address wrap with overlapping destination
        ram[62] = 8'hA1; ram[63] = 8'hB2; ram[0] = 8'hC3; ram[1] = 8'hD4;
        exp_ram[62] = 8'hA1; exp_ram[63] = 8'hB2; exp_ram[0] = 8'hC3; exp_ram[1] = 8'hD4;
        run_copy(62, 1, 4, 0, 1, 0);

        // Write stall on the first word
        run_copy(5, 20, 3, 2, 0, 0);

        // Zero-length copy
        run_copy(7, 9, 0, 0, 1, 0);

        // Reset mid-copy, then a fresh copy
        reset_mid_copy(40, 50);
        run_copy(40, 50, 5, 0, 1, 0);

        // Start pulses while busy are ignored
        run_copy(30, 44, 6, 0, 1, 1);

        // Whole-RAM copy
        run_copy(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), DEPTH, 0, 1, 0);

        // Random commands with random back-pressure
        for (int k = 0; k < 8; k++) begin
            run_copy(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)),
                     int'($urandom_range(0, DEPTH)), 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
